// File: rtl/cdb_broadcaster.sv
// Transmit end of the common data bus. Each functional unit has its own completion FIFO.
// A round-robin arbiter picks one FIFO head per cycle and drives it onto the registered bus.
module cdb_broadcaster #(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]     fu_tag,
  input  logic [NUM_FU*XLEN-1:0]      fu_value,
  output logic [NUM_FU-1:0]           fu_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic [$clog2(NUM_FU)-1:0]   cdb_fu_idx
);

  localparam int IDX_W = $clog2(NUM_FU);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tag_mem [NUM_FU][DEPTH];
  logic [XLEN-1:0]  val_mem [NUM_FU][DEPTH];
  logic [PTR_W-1:0] head    [NUM_FU];
  logic [PTR_W-1:0] tail    [NUM_FU];
  logic [CNT_W-1:0] count   [NUM_FU];

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   sum;
  logic             grant_valid;
  logic             flush;
  logic [NUM_FU-1:0] enq;
  logic [NUM_FU-1:0] deq;
  logic [TAG_W-1:0] head_tag;
  logic [XLEN-1:0]  head_value;

  assign flush = reset | squash;

  // Ready comes from occupancy alone, so a full FIFO never accepts even when granted.
  always_comb begin
    fu_ready = '0;
    enq      = '0;
    deq      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] != CNT_W'(DEPTH));
      enq[i]      = fu_valid[i] & fu_ready[i];
      deq[i]      = grant_valid & (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_FU)) begin
        sum = sum - (IDX_W+1)'(NUM_FU);
      end
      cand = sum[IDX_W-1:0];
      if (!grant_valid && (count[cand] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_next    = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
    head_tag   = tag_mem[grant_idx][head[grant_idx]];
    head_value = val_mem[grant_idx][head[grant_idx]];
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!flush && enq[i]) begin
        tag_mem[i][tail[i]] <= fu_tag[i*TAG_W +: TAG_W];
        val_mem[i][tail[i]] <= fu_value[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_fu_idx <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      if (grant_valid) begin
        rr_ptr <= rr_next;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (enq[i]) begin
          tail[i] <= tail[i] + PTR_W'(1);
        end
        if (deq[i]) begin
          head[i] <= head[i] + PTR_W'(1);
        end
        if (enq[i] && !deq[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!enq[i] && deq[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      // Idle cycles drive zeros so no stale tag can match a snooper.
      cdb_valid  <= grant_valid;
      cdb_tag    <= grant_valid ? head_tag   : '0;
      cdb_value  <= grant_valid ? head_value : '0;
      cdb_fu_idx <= grant_valid ? grant_idx  : '0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed vector table plus randomized traffic against a queue-based model.
module tb_cdb_broadcaster;

  localparam int NUM_FU = 4;
  localparam int DEPTH  = 2;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic         squash;
  logic [3:0]   fu_valid;
  logic [19:0]  fu_tag;
  logic [127:0] fu_value;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_value;
  logic [1:0]   cdb_fu_idx;

  always #5 clock = ~clock;

  cdb_broadcaster #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .fu_valid   (fu_valid),
    .fu_tag     (fu_tag),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .cdb_fu_idx (cdb_fu_idx)
  );

  typedef struct packed {
    logic       rst;
    logic       sq;
    logic [3:0] v;
    logic [19:0] tags;
    logic [3:0] rdy;
    logic       cv;
    logic [4:0] ct;
    logic [1:0] ci;
  } tvec_t;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] val;
  } ent_t;

  int checks   = 0;
  int failures = 0;

  ent_t        mq [NUM_FU][$];
  int          m_rr = 0;
  logic        m_v;
  logic [4:0]  m_t;
  logic [31:0] m_val;
  logic [1:0]  m_i;
  logic [3:0]  last_rdy;

  tvec_t tbl[$];

  function automatic logic [31:0] val_of(input logic [4:0] t);
    return {t, 3'b101, ~t, 3'b011, 16'hBEEF};
  endfunction

  function automatic logic [127:0] vals_from(input logic [19:0] t);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = val_of(t[i*5 +: 5]);
    return r;
  endfunction

  function automatic logic [19:0] tg(input int t3, input int t2, input int t1, input int t0);
    return {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
  endfunction

  function automatic tvec_t vec(input logic rst, input logic sq, input logic [3:0] v,
                                input logic [19:0] tags, input logic [3:0] rdy,
                                input logic cv, input int ct, input int ci);
    tvec_t e;
    e.rst = rst; e.sq = sq; e.v = v; e.tags = tags; e.rdy = rdy;
    e.cv = cv; e.ct = 5'(ct); e.ci = 2'(ci);
    return e;
  endfunction

  function automatic tvec_t idle(input logic [3:0] rdy, input logic cv, input int ct, input int ci);
    return vec(1'b0, 1'b0, 4'b0000, 20'h0, rdy, cv, ct, ci);
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: one queue per FU, round-robin pick over non-empty queues, pop before push.
  task automatic model_edge(input logic r, input logic s, input logic [3:0] v,
                            input logic [19:0] t, input logic [127:0] val, input logic [3:0] rdy);
    int w;
    ent_t e;
    if (r || s) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      m_rr = 0; m_v = 1'b0; m_t = '0; m_val = '0; m_i = '0;
    end else begin
      w = -1;
      for (int k = 0; k < NUM_FU; k++) begin
        if (w < 0 && mq[(m_rr + k) % NUM_FU].size() > 0) w = (m_rr + k) % NUM_FU;
      end
      if (w >= 0) begin
        e = mq[w].pop_front();
        m_v = 1'b1; m_t = e.tag; m_val = e.val; m_i = 2'(w);
        m_rr = (w + 1) % NUM_FU;
      end else begin
        m_v = 1'b0; m_t = '0; m_val = '0; m_i = '0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (v[i] && rdy[i]) begin
          e.tag = t[i*5 +: 5];
          e.val = val[i*32 +: 32];
          mq[i].push_back(e);
        end
      end
    end
  endtask

  task automatic step(input string nm, input logic r, input logic s, input logic [3:0] v,
                      input logic [19:0] t, input logic [127:0] val,
                      input bit use_tbl, input tvec_t e);
    logic [3:0] mrdy;
    @(negedge clock);
    reset = r; squash = s; fu_valid = v; fu_tag = t; fu_value = val;
    #1;
    for (int i = 0; i < NUM_FU; i++) mrdy[i] = (mq[i].size() != DEPTH);
    last_rdy = mrdy;
    chk({nm, " model ready"}, 40'(fu_ready), 40'(mrdy));
    if (use_tbl) chk({nm, " ready"}, 40'(fu_ready), 40'(e.rdy));
    @(posedge clock);
    model_edge(r, s, v, t, val, mrdy);
    #1;
    chk({nm, " model bus"}, {cdb_valid, cdb_tag, cdb_value, cdb_fu_idx}, {m_v, m_t, m_val, m_i});
    if (use_tbl)
      chk({nm, " bus"}, {cdb_valid, cdb_tag, cdb_value, cdb_fu_idx},
          {e.cv, e.ct, (e.cv ? val_of(e.ct) : 32'h0), e.ci});
  endtask

  logic [3:0]  pv;
  logic [4:0]  ptag [4];
  logic [31:0] pval [4];

  initial begin
    logic [3:0]   rv;
    logic [19:0]  rt;
    logic [127:0] rval;
    logic         rr_s, rr_r;
    int           guard;

    reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
    repeat (2) @(posedge clock);

    tbl.push_back(vec(1, 0, 4'b0000, tg(0,0,0,0), 4'hF, 0, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(idle(4'hF, 0, 0, 0));
    // single result, two-cycle latency
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,3), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 1, 3, 0));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    // contention from rr_ptr=0, then FU1/FU3 only
    tbl.push_back(vec(1, 0, 4'b0000, tg(0,0,0,0), 4'hF, 0, 0, 0));
    tbl.push_back(vec(0, 0, 4'b1111, tg(4,3,2,1), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 1, 1, 0));
    tbl.push_back(idle(4'hF, 1, 2, 1));
    tbl.push_back(idle(4'hF, 1, 3, 2));
    tbl.push_back(idle(4'hF, 1, 4, 3));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    tbl.push_back(vec(0, 0, 4'b1010, tg(6,0,5,0), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 1, 5, 1));
    tbl.push_back(idle(4'hF, 1, 6, 3));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    // back-pressure on FU2, tag 9 held until accepted
    tbl.push_back(vec(0, 0, 4'b1011, tg(13,0,11,10), 4'hF, 0, 0, 0));
    tbl.push_back(vec(0, 0, 4'b1111, tg(23,7,21,20), 4'hF, 1, 10, 0));
    tbl.push_back(vec(0, 0, 4'b0100, tg(0,8,0,0), 4'b0101, 1, 11, 1));
    tbl.push_back(vec(0, 0, 4'b0100, tg(0,9,0,0), 4'b0011, 1, 7, 2));
    tbl.push_back(vec(0, 0, 4'b0100, tg(0,9,0,0), 4'b0111, 1, 13, 3));
    tbl.push_back(idle(4'b1011, 1, 20, 0));
    tbl.push_back(idle(4'b1011, 1, 21, 1));
    tbl.push_back(idle(4'b1011, 1, 8, 2));
    tbl.push_back(idle(4'hF, 1, 23, 3));
    tbl.push_back(idle(4'hF, 1, 9, 2));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    // squash with queued data, then squash together with reset
    tbl.push_back(vec(0, 0, 4'b0011, tg(0,0,15,14), 4'hF, 0, 0, 0));
    tbl.push_back(vec(0, 1, 4'b0001, tg(0,0,0,16), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,17), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 1, 17, 0));
    tbl.push_back(vec(1, 1, 4'b1111, tg(4,3,2,1), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    // same-cycle enqueue/dequeue, full FIFO granted without pass-through
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,24), 4'hF, 0, 0, 0));
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,25), 4'hF, 1, 24, 0));
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,26), 4'hF, 1, 25, 0));
    tbl.push_back(vec(0, 0, 4'b0011, tg(0,0,28,27), 4'hF, 1, 26, 0));
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,29), 4'hF, 1, 28, 1));
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,30), 4'b1110, 1, 27, 0));
    tbl.push_back(vec(0, 0, 4'b0001, tg(0,0,0,30), 4'hF, 1, 29, 0));
    tbl.push_back(idle(4'hF, 1, 30, 0));
    tbl.push_back(idle(4'hF, 0, 0, 0));
    // tag 0 is a legal broadcast
    tbl.push_back(vec(0, 0, 4'b0100, tg(0,0,0,0), 4'hF, 0, 0, 0));
    tbl.push_back(idle(4'hF, 1, 0, 2));
    tbl.push_back(idle(4'hF, 0, 0, 0));

    foreach (tbl[k])
      step($sformatf("tbl[%0d]", k), tbl[k].rst, tbl[k].sq, tbl[k].v, tbl[k].tags,
           vals_from(tbl[k].tags), 1'b1, tbl[k]);

    // Random traffic: each FU holds its result until accepted.
    pv = '0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 45) begin
          pv[i]   = 1'b1;
          ptag[i] = 5'($urandom_range(0, 31));
          pval[i] = $urandom;
        end
      end
      rv = pv;
      for (int i = 0; i < 4; i++) begin
        rt[i*5 +: 5]    = ptag[i];
        rval[i*32 +: 32] = pval[i];
      end
      rr_s = ($urandom_range(0, 99) == 0);
      rr_r = ($urandom_range(0, 299) == 0);
      step($sformatf("rnd[%0d]", n), rr_r, rr_s, rv, rt, rval, 1'b0, '0);
      pv = pv & ~(rv & last_rdy);
    end

    guard = 0;
    while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0 && guard < 12) begin
      step($sformatf("drain[%0d]", guard), 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, '0);
      guard++;
    end
    chk("drain empty", 40'(mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()), 40'd0);
    step("final idle", 1'b0, 1'b0, 4'b0000, '0, '0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
